// File: rtl/vec_mem_pkg.sv
// Shared encodings, FSM state type and lane helper for the vector MEM stage.
package vec_mem_pkg;

    // Control word layout: bit 3 flags a memory op, bits 2:0 carry the opcode
    localparam int         CTRL_W   = 4;
    localparam int         MEM_BIT  = 3;
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Bit offset of the lowest bit of a lane inside a packed vector
    function automatic int lane_lo(input int lane, input int elem_w);
        return lane * elem_w;
    endfunction

endpackage

// File: rtl/vec_lane_mask.sv
// Combinational per-lane gate: lanes whose mask bit is clear are forced to zero.
module vec_lane_mask
    import vec_mem_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int ELEM_W = 24
) (
    input  logic [LANES*ELEM_W-1:0] data_i,
    input  logic [LANES-1:0]        mask_i,
    output logic [LANES*ELEM_W-1:0] data_o
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int LO = lane_lo(gi, ELEM_W);
        // Pass the lane through only when its enable bit is set
        assign data_o[LO +: ELEM_W] = mask_i[gi] ? data_i[LO +: ELEM_W] : '0;
    end

endmodule

// File: rtl/vec_mem_stage.sv
// Vector MEM stage between EX and WB: issues masked loads/stores to a
// variable-latency memory with a bounded response wait, otherwise forwards
// the ALU or reduction result. One op in flight at a time.
module vec_mem_stage
    import vec_mem_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int ELEM_W  = 24,
    parameter int ADDR_W  = 21,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Upstream (EX)
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [LANES*ELEM_W-1:0] in_wdata,
    input  logic [LANES-1:0]        in_mask,
    input  logic [LANES*ELEM_W-1:0] in_res_alu,
    input  logic [LANES*ELEM_W-1:0] in_res_sum,
    // Memory request
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [LANES*ELEM_W-1:0] mem_req_wdata,
    output logic [LANES-1:0]        mem_req_mask,
    // Memory response
    input  logic                    mem_rsp_valid,
    input  logic [LANES*ELEM_W-1:0] mem_rsp_rdata,
    // Downstream (WB)
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ELEM_W-1:0] out_data,
    output logic                    out_is_load,
    output logic                    out_err
);

    localparam int              VW       = LANES * ELEM_W;
    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mem_req_valid_q;
    logic               mem_req_we_q;
    logic [ADDR_W-1:0]  mem_req_addr_q;
    logic [VW-1:0]      mem_req_wdata_q;
    logic [LANES-1:0]   mem_req_mask_q;
    logic               out_valid_q;
    logic [VW-1:0]      out_data_q;
    logic               out_is_load_q;
    logic               out_err_q;

    logic               accept;
    logic               is_ld_st;
    logic [VW-1:0]      rsp_masked;

    // Ready only in IDLE and never while reset is held
    assign in_ready = rst_n && (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign is_ld_st = (in_ctrl[2:0] == OP_LOAD) || (in_ctrl[2:0] == OP_STORE);

    // Load data is gated by the mask that was sent with the request
    vec_lane_mask #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W)
    ) u_rsp_mask (
        .data_i (mem_rsp_rdata),
        .mask_i (mem_req_mask_q),
        .data_o (rsp_masked)
    );

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_mask_q  <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_is_load_q   <= 1'b0;
            out_err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_ctrl[MEM_BIT] && is_ld_st && (in_mask != '0)) begin
                            state_q         <= ST_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_we_q    <= (in_ctrl[2:0] == OP_STORE);
                            mem_req_addr_q  <= in_addr;
                            mem_req_wdata_q <= in_wdata;
                            mem_req_mask_q  <= in_mask;
                        end else begin
                            // Non-memory result, illegal op, or empty-mask memory op
                            state_q       <= ST_OUT;
                            out_valid_q   <= 1'b1;
                            out_is_load_q <= 1'b0;
                            if (!in_ctrl[MEM_BIT]) begin
                                out_data_q <= in_ctrl[0] ? in_res_sum : in_res_alu;
                                out_err_q  <= 1'b0;
                            end else if (is_ld_st) begin
                                out_data_q <= '0;
                                out_err_q  <= 1'b0;
                            end else begin
                                out_data_q <= in_res_alu;
                                out_err_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (mem_req_we_q) begin
                            state_q       <= ST_OUT;
                            out_valid_q   <= 1'b1;
                            out_data_q    <= '0;
                            out_is_load_q <= 1'b0;
                            out_err_q     <= 1'b0;
                        end else begin
                            state_q <= ST_RSP;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_RSP: begin
                    // A response on the last allowed cycle still wins over timeout
                    if (mem_rsp_valid) begin
                        state_q       <= ST_OUT;
                        out_valid_q   <= 1'b1;
                        out_data_q    <= rsp_masked;
                        out_is_load_q <= 1'b1;
                        out_err_q     <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= ST_OUT;
                        out_valid_q   <= 1'b1;
                        out_data_q    <= '0;
                        out_is_load_q <= 1'b0;
                        out_err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_mask  = mem_req_mask_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_is_load   = out_is_load_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed bench for vec_mem_stage: expected results are queued when an op is
// driven and compared when the stage presents its output.
module tb_vec_mem_stage;

    localparam int LANES   = 8;
    localparam int ELEM_W  = 24;
    localparam int ADDR_W  = 21;
    localparam int TIMEOUT = 8;
    localparam int VW      = LANES * ELEM_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_ctrl;
    logic [ADDR_W-1:0] in_addr;
    logic [VW-1:0]     in_wdata;
    logic [LANES-1:0]  in_mask;
    logic [VW-1:0]     in_res_alu;
    logic [VW-1:0]     in_res_sum;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [VW-1:0]     mem_req_wdata;
    logic [LANES-1:0]  mem_req_mask;
    logic              mem_rsp_valid;
    logic [VW-1:0]     mem_rsp_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_data;
    logic              out_is_load;
    logic              out_err;

    vec_mem_stage #(
        .LANES   (LANES),
        .ELEM_W  (ELEM_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ctrl       (in_ctrl),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_mask       (in_mask),
        .in_res_alu    (in_res_alu),
        .in_res_sum    (in_res_sum),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_mask  (mem_req_mask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_is_load   (out_is_load),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] data;
        logic          is_load;
        logic          err;
        logic          chk_load;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%h exp=%h", n_vec, tag, obs, exp);
    endtask

    task automatic push(input logic [VW-1:0] d, input logic ld, input logic e, input logic cl);
        exp_t x;
        x.data = d; x.is_load = ld; x.err = e; x.chk_load = cl;
        sb.push_back(x);
    endtask

    // Present one op for a single accepting edge
    task automatic send(input logic [3:0] c, input logic [ADDR_W-1:0] a, input logic [VW-1:0] wd,
                        input logic [LANES-1:0] m, input logic [VW-1:0] alu, input logic [VW-1:0] sum);
        chk("send_in_ready", VW'(in_ready), VW'(1'b1));
        in_valid = 1'b1; in_ctrl = c; in_addr = a; in_wdata = wd;
        in_mask = m; in_res_alu = alu; in_res_sum = sum;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, compare against the scoreboard head, then handshake
    task automatic drain(input string tag, input int max_cyc);
        exp_t x;
        int   k;
        k = 0;
        while (!out_valid && k < max_cyc) begin
            tick();
            k++;
        end
        chk({tag, "_out_valid"}, VW'(out_valid), VW'(1'b1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, VW'(0), VW'(1));
        end else begin
            x = sb.pop_front();
            chk({tag, "_data"}, out_data, x.data);
            chk({tag, "_err"}, VW'(out_err), VW'(x.err));
            if (x.chk_load) chk({tag, "_is_load"}, VW'(out_is_load), VW'(x.is_load));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, VW'(out_valid), VW'(1'b0));
        chk({tag, "_in_ready_back"}, VW'(in_ready), VW'(1'b1));
    endtask

    logic [VW-1:0] sum_pat, alu_pat, wd_pat, ones, ld_exp;

    initial begin
        sum_pat = {LANES{24'hA5A5A5}};
        alu_pat = {LANES{24'h3C1E0F}};
        wd_pat  = {24'h777777, 24'h666666, 24'h555555, 24'h444444,
                   24'h333333, 24'h222222, 24'h111111, 24'h0ABCDE};
        ones    = '1;
        ld_exp  = {96'h0, {4{24'hFFFFFF}}};

        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_addr = '0; in_wdata = '0;
        in_mask = '0; in_res_alu = '0; in_res_sum = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", VW'(in_ready), VW'(1'b0));
        chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
        chk("rst_req_valid", VW'(mem_req_valid), VW'(1'b0));
        chk("rst_out_data", out_data, '0);
        chk("rst_req_addr", VW'(mem_req_addr), VW'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", VW'(in_ready), VW'(1'b1));

        // PASS selecting res_sum, held three cycles with out_ready low
        push(sum_pat, 1'b0, 1'b0, 1'b1);
        send(4'b0001, '0, '0, '0, alu_pat, sum_pat);
        chk("pass_lat1_valid", VW'(out_valid), VW'(1'b1));
        chk("pass_in_ready_low", VW'(in_ready), VW'(1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pass_hold_valid", VW'(out_valid), VW'(1'b1));
            chk("pass_hold_data", out_data, sum_pat);
        end
        drain("pass_sum", 4);

        // PASS selecting res_alu
        push(alu_pat, 1'b0, 1'b0, 1'b1);
        send(4'b0000, '0, '0, '0, alu_pat, sum_pat);
        drain("pass_alu", 4);

        // STORE with memory stalling four cycles
        send(4'b1001, 21'h1F, wd_pat, 8'hF0, alu_pat, sum_pat);
        for (int i = 0; i < 5; i++) begin
            chk("st_req_valid", VW'(mem_req_valid), VW'(1'b1));
            chk("st_req_we", VW'(mem_req_we), VW'(1'b1));
            chk("st_req_addr", VW'(mem_req_addr), VW'(21'h1F));
            chk("st_req_wdata", mem_req_wdata, wd_pat);
            chk("st_req_mask", VW'(mem_req_mask), VW'(8'hF0));
            chk("st_no_out", VW'(out_valid), VW'(1'b0));
            if (i < 4) tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("st_req_dropped", VW'(mem_req_valid), VW'(1'b0));
        push('0, 1'b0, 1'b0, 1'b1);
        drain("store", 4);

        // Response while idle must not disturb the stage
        mem_rsp_valid = 1'b1; mem_rsp_rdata = ones;
        tick();
        mem_rsp_valid = 1'b0;
        chk("idle_rsp_no_out", VW'(out_valid), VW'(1'b0));
        chk("idle_rsp_ready", VW'(in_ready), VW'(1'b1));

        // LOAD with lower-half mask, response seven cycles after the request
        mem_req_ready = 1'b1;
        send(4'b1000, 21'h155, '0, 8'h0F, alu_pat, sum_pat);
        chk("ld_req_valid", VW'(mem_req_valid), VW'(1'b1));
        chk("ld_req_we", VW'(mem_req_we), VW'(1'b0));
        tick();
        mem_req_ready = 1'b0;
        chk("ld_req_done", VW'(mem_req_valid), VW'(1'b0));
        for (int i = 0; i < 6; i++) tick();
        chk("ld_wait_no_out", VW'(out_valid), VW'(1'b0));
        mem_rsp_valid = 1'b1; mem_rsp_rdata = ones;
        push(ld_exp, 1'b1, 1'b0, 1'b1);
        tick();
        mem_rsp_valid = 1'b0;
        drain("load", 2);

        // LOAD timeout: out_valid after exactly TIMEOUT response-wait cycles
        mem_req_ready = 1'b1;
        send(4'b1000, 21'h40, '0, 8'hFF, alu_pat, sum_pat);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_not_yet", VW'(out_valid), VW'(1'b0));
        tick();
        chk("to_fired", VW'(out_valid), VW'(1'b1));
        // Late response while result is held must be ignored
        mem_rsp_valid = 1'b1; mem_rsp_rdata = ones;
        tick();
        mem_rsp_valid = 1'b0;
        push('0, 1'b0, 1'b1, 1'b0);
        drain("timeout", 2);
        push(sum_pat, 1'b0, 1'b0, 1'b1);
        send(4'b0011, '0, '0, '0, alu_pat, sum_pat);
        drain("after_to", 4);

        // Illegal memory opcode
        push(alu_pat, 1'b0, 1'b1, 1'b1);
        send(4'b1111, '0, '0, 8'hFF, alu_pat, sum_pat);
        drain("illegal", 4);

        // Empty-mask LOAD: no request issued
        push('0, 1'b0, 1'b0, 1'b0);
        send(4'b1000, 21'h3, '0, 8'h00, alu_pat, sum_pat);
        chk("m0_no_req", VW'(mem_req_valid), VW'(1'b0));
        chk("m0_out_now", VW'(out_valid), VW'(1'b1));
        drain("mask0", 2);

        // Asynchronous reset in the middle of a request
        send(4'b1001, 21'h1ABCD, wd_pat, 8'h3C, alu_pat, sum_pat);
        chk("mid_req_valid", VW'(mem_req_valid), VW'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req_valid", VW'(mem_req_valid), VW'(1'b0));
        chk("ar_in_ready", VW'(in_ready), VW'(1'b0));
        chk("ar_req_addr", VW'(mem_req_addr), VW'(0));
        chk("ar_req_we", VW'(mem_req_we), VW'(1'b0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("ar_idle_ready", VW'(in_ready), VW'(1'b1));
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = ones;
        tick();
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        chk("ar_stale_rsp_no_out", VW'(out_valid), VW'(1'b0));
        push(alu_pat, 1'b0, 1'b0, 1'b1);
        send(4'b0000, '0, '0, '0, alu_pat, sum_pat);
        drain("post_ar", 4);

        chk("sb_empty", VW'(sb.size()), VW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
